// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage and its neighbours:
//   - address-register select codes driven by the control FSM
//   - fetch FSM state encoding
//   - canonical NOP word, also used by the decoder
//   - word alignment helper for fetch targets
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [1:0] ADDRESS_SELECT_ALU = 2'b00;
    localparam logic [1:0] ADDRESS_SELECT_PC  = 2'b01;
    localparam logic [1:0] ADDRESS_SELECT_INC = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry FIFO holding {instruction, address} pairs returned by memory.
// Clear has priority over push/pop. Pop on empty and push on full are ignored.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write one entry
//   pop                 remove the head entry
//   clear               flush all entries
//   head                current head entry (reset value until first push)
//   count               number of valid entries (0..DEPTH)
//   empty, full         occupancy flags
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int               DEPTH       = 2,
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              AW          = $clog2(DEPTH),
    localparam int              CW          = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy so the pointers never corrupt.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_VALUE;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view and flags derived from registered state.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
        empty = (count_r == {CW{1'b0}});
        full  = (count_r == CW'(DEPTH));
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the fetch address, issues word reads over a
// req/ack handshake, buffers returned words in fetch_queue and presents them
// with valid/ready. A redirect (update_address with ALU select) flushes the
// queue; an already-issued request is never withdrawn, its data is dropped.
// Optional build macro: FETCH_STATS_EN adds stat_fetched / stat_flushes.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   update_address, address_reg_sel control FSM address update (ALU = redirect)
//   alu_result                      redirect target
//   mem_req, mem_addr               registered read request / word address
//   mem_ack, mem_rdata              one-cycle completion with data
//   instr_out, instr_pc             queue head word and its address
//   instr_pc_plus8                  instr_pc + 8
//   instr_valid, instr_ready        head handshake
//   stat_fetched, stat_flushes      (FETCH_STATS_EN) accepted words / redirects
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_address,
    input  logic [1:0]  address_reg_sel,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus8,
    output logic        instr_valid,
`ifdef FETCH_STATS_EN
    input  logic        instr_ready,
    output logic [31:0] stat_fetched,
    output logic [15:0] stat_flushes
`else
    input  logic        instr_ready
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_r;
    fetch_state_t  state_s;
    logic [31:0]   fetch_addr_r;
    logic [31:0]   fetch_addr_s;
    logic          mem_req_s;
    logic [31:0]   mem_addr_s;
    logic          redirect_s;
    logic [31:0]   target_s;
    logic          pop_s;
    logic          push_s;
    logic [CW:0]   count_after_push_s;
    logic [63:0]   q_head;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;

    // Only the ALU select redirects; PC/INC updates are consumed via instr_ready.
    always_comb begin
        target_s = word_align(alu_result);
        case (address_reg_sel)
            ADDRESS_SELECT_ALU: redirect_s = update_address;
            ADDRESS_SELECT_PC:  redirect_s = 1'b0;
            ADDRESS_SELECT_INC: redirect_s = 1'b0;
            default:            redirect_s = 1'b0;
        endcase
    end

    // A pop coinciding with a redirect is void because the queue is being cleared.
    always_comb begin
        pop_s              = instr_valid && instr_ready && !redirect_s;
        count_after_push_s = {1'b0, q_count} + {{CW{1'b0}}, 1'b1}
                           - {{CW{1'b0}}, pop_s};
    end

    // Fetch FSM next state, next request and next fetch address.
    always_comb begin
        state_s      = state_r;
        fetch_addr_s = fetch_addr_r;
        mem_req_s    = mem_req;
        mem_addr_s   = mem_addr;
        push_s       = 1'b0;
        case (state_r)
            FETCH_IDLE: begin
                if (redirect_s) begin
                    // New target is requested once the queue clear has landed.
                    fetch_addr_s = target_s;
                end else if ({1'b0, q_count} < (CW+1)'(DEPTH)) begin
                    mem_req_s  = 1'b1;
                    mem_addr_s = fetch_addr_r;
                    state_s    = FETCH_REQ;
                end else begin
                    state_s = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (mem_ack) begin
                    if (redirect_s) begin
                        fetch_addr_s = target_s;
                        mem_req_s    = 1'b0;
                        state_s      = FETCH_IDLE;
                    end else begin
                        push_s       = 1'b1;
                        fetch_addr_s = fetch_addr_r + 32'd4;
                        if (count_after_push_s < (CW+1)'(DEPTH)) begin
                            // Room for another word: keep the request back-to-back.
                            mem_addr_s = fetch_addr_r + 32'd4;
                        end else begin
                            mem_req_s = 1'b0;
                            state_s   = FETCH_IDLE;
                        end
                    end
                end else if (redirect_s) begin
                    // Request stays on the bus; its data is discarded in DROP.
                    fetch_addr_s = target_s;
                    state_s      = FETCH_DROP;
                end else begin
                    state_s = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                if (redirect_s) begin
                    fetch_addr_s = target_s;
                end else begin
                    fetch_addr_s = fetch_addr_r;
                end
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    state_s   = FETCH_IDLE;
                end else begin
                    state_s = FETCH_DROP;
                end
            end
            default: begin
                mem_req_s = 1'b0;
                state_s   = FETCH_IDLE;
            end
        endcase
    end

    // FSM state, fetch address and the registered memory request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= FETCH_IDLE;
            fetch_addr_r <= RESET_VECTOR;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_VECTOR;
        end else begin
            state_r      <= state_s;
            fetch_addr_r <= fetch_addr_s;
            mem_req      <= mem_req_s;
            mem_addr     <= mem_addr_s;
        end
    end

    fetch_queue #(
        .DEPTH       (DEPTH),
        .WIDTH       (64),
        .RESET_VALUE ({32'h0000_0000, RESET_VECTOR})
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({mem_rdata, mem_addr}),
        .pop       (pop_s),
        .clear     (redirect_s),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Head presentation; R15 reads as the instruction address plus 8.
    always_comb begin
        instr_out      = q_head[63:32];
        instr_pc       = q_head[31:0];
        instr_pc_plus8 = q_head[31:0] + 32'd8;
        instr_valid    = !q_empty;
    end

`ifdef FETCH_STATS_EN
    // Free-running statistics; both wrap at their maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched <= 32'd0;
            stat_flushes <= 16'd0;
        end else begin
            if (push_s) begin
                stat_fetched <= stat_fetched + 32'd1;
            end else begin
                stat_fetched <= stat_fetched;
            end
            if (redirect_s) begin
                stat_flushes <= stat_flushes + 16'd1;
            end else begin
                stat_flushes <= stat_flushes;
            end
        end
    end
`endif

    logic unused_s;
    // The full flag is not needed here: issue accounting already prevents overflow.
    always_comb begin
        unused_s = q_full;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (DEPTH=2, RESET_VECTOR=0). Inputs change 1 ns
// after a rising edge, outputs are compared 1 ns after a rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        update_address = 1'b0;
    logic [1:0]  address_reg_sel = 2'b01;
    logic [31:0] alu_result = 32'h0000_0000;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0000_0000;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus8;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_unit #(
        .DEPTH        (2),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .update_address  (update_address),
        .address_reg_sel (address_reg_sel),
        .alu_result      (alu_result),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_pc_plus8  (instr_pc_plus8),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory content pattern: address xor a fixed tag.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ack = 1'b0;
        update_address = 1'b0;
        step();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        step();
        check_vec("rst_req",   {31'd0, mem_req},     32'd0);
        check_vec("rst_addr",  mem_addr,             32'h0000_0000);
        check_vec("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_vec("rst_out",   instr_out,            32'h0000_0000);
        check_vec("rst_pc",    instr_pc,             32'h0000_0000);
        check_vec("rst_pc8",   instr_pc_plus8,       32'h0000_0008);
        reset = 1'b0;
        step();
        check_vec("first_req",  {31'd0, mem_req}, 32'd1);
        check_vec("first_addr", mem_addr,         32'h0000_0000);

        // ---------------- streaming, ack every cycle, ready=1 ----------------
        instr_ready = 1'b1;
        mem_ack     = 1'b1;
        // A PC select update must not redirect.
        update_address  = 1'b1;
        address_reg_sel = 2'b01;
        alu_result      = 32'h0000_0400;
        for (int i = 1; i <= 4; i++) begin
            mem_rdata = word_at(mem_addr);
            step();
            check_vec("str_addr",  mem_addr,             32'(4 * i));
            check_vec("str_valid", {31'd0, instr_valid}, 32'd1);
            check_vec("str_pc",    instr_pc,             32'(4 * (i - 1)));
            check_vec("str_pc8",   instr_pc_plus8,       32'(4 * (i - 1) + 8));
            check_vec("str_out",   instr_out,            word_at(32'(4 * (i - 1))));
        end
        update_address = 1'b0;
        instr_ready    = 1'b0;

        // ---------------- queue full, ready=0 ----------------
        do_reset();
        mem_ack = 1'b1;
        mem_rdata = word_at(32'h0000_0000);
        step();
        check_vec("full_addr1", mem_addr, 32'h0000_0004);
        mem_rdata = word_at(32'h0000_0004);
        step();
        mem_ack = 1'b0;
        check_vec("full_req0", {31'd0, mem_req}, 32'd0);
        check_vec("full_out",  instr_out,        word_at(32'h0000_0000));
        step();
        step();
        check_vec("full_hold", {31'd0, mem_req}, 32'd0);
        instr_ready = 1'b1;
        step();
        check_vec("resume_pc",  instr_pc,         32'h0000_0004);
        check_vec("resume_req0",{31'd0, mem_req}, 32'd0);
        step();
        check_vec("resume_req", {31'd0, mem_req}, 32'd1);
        check_vec("resume_addr", mem_addr,        32'h0000_0008);

        // ---------------- redirect while request to 8 pending ----------------
        update_address  = 1'b1;
        address_reg_sel = 2'b00;
        alu_result      = 32'h0000_0103;
        step();
        update_address = 1'b0;
        check_vec("drop_req",   {31'd0, mem_req},     32'd1);
        check_vec("drop_addr",  mem_addr,             32'h0000_0008);
        check_vec("drop_valid", {31'd0, instr_valid}, 32'd0);
        step();
        step();
        check_vec("drop_hold", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = word_at(32'h0000_0008);
        step();
        mem_ack = 1'b0;
        check_vec("drop_done",   {31'd0, mem_req},     32'd0);
        check_vec("drop_discard",{31'd0, instr_valid}, 32'd0);
        step();
        check_vec("tgt_req",   {31'd0, mem_req},     32'd1);
        check_vec("tgt_addr",  mem_addr,             32'h0000_0100);
        check_vec("tgt_valid", {31'd0, instr_valid}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = word_at(32'h0000_0100);
        step();
        check_vec("tgt_pc",   instr_pc,  32'h0000_0100);
        check_vec("tgt_out",  instr_out, word_at(32'h0000_0100));
        check_vec("tgt_next", mem_addr,  32'h0000_0104);

        // ---------------- redirect with same-cycle ack and pop ----------------
        mem_rdata       = word_at(32'h0000_0104);
        update_address  = 1'b1;
        address_reg_sel = 2'b00;
        alu_result      = 32'h0000_0200;
        step();
        update_address = 1'b0;
        mem_ack        = 1'b0;
        check_vec("same_valid", {31'd0, instr_valid}, 32'd0);
        check_vec("same_req",   {31'd0, mem_req},     32'd0);
        step();
        check_vec("same_tgt", mem_addr, 32'h0000_0200);
        // An INC select update alongside an ack must not redirect.
        update_address  = 1'b1;
        address_reg_sel = 2'b10;
        alu_result      = 32'h0000_0300;
        mem_ack         = 1'b1;
        mem_rdata       = word_at(32'h0000_0200);
        step();
        check_vec("inc_addr", mem_addr, 32'h0000_0204);
        check_vec("inc_pc",   instr_pc, 32'h0000_0200);

        // ---------------- address wrap ----------------
        address_reg_sel = 2'b00;
        alu_result      = 32'hFFFF_FFFF;
        mem_rdata       = word_at(32'h0000_0204);
        step();
        update_address = 1'b0;
        mem_ack        = 1'b0;
        step();
        check_vec("wrap_tgt", mem_addr, 32'hFFFF_FFFC);
        mem_ack   = 1'b1;
        mem_rdata = word_at(32'hFFFF_FFFC);
        step();
        check_vec("wrap_next", mem_addr,       32'h0000_0000);
        check_vec("wrap_pc",   instr_pc,       32'hFFFF_FFFC);
        check_vec("wrap_pc8",  instr_pc_plus8, 32'h0000_0004);

        // ---------------- reset mid-request ----------------
        mem_ack = 1'b0;
        reset   = 1'b1;
        #1;
        check_vec("mid_rst_req",   {31'd0, mem_req},     32'd0);
        check_vec("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        check_vec("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check_vec("post_rst_req",   {31'd0, mem_req},     32'd1);
        check_vec("post_rst_addr",  mem_addr,             32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
